// File: rtl/sound_event_scheduler.sv
// ---------------------------------------------------------------------------
// sound_event_scheduler
//
// Queues win/lose sound requests in a 2-entry FIFO and plays each one as a
// short sequence of notes. A single FSM (IDLE / NOTE / GAP) walks the note
// table and drives the registered tone-generator outputs.
//
// Optional feature macro: SOUND_GAP_EN
//   defined   -> GAP_TICKS silent cycles are inserted between the notes of
//                a sequence (GAP state compiled in)
//   undefined -> notes play back-to-back, no GAP logic is built
//
// Parameters
//   NOTE_TICKS  clock cycles per note (1 .. 2^26-1)
//   GAP_TICKS   silent cycles between notes (1 .. 255), SOUND_GAP_EN only
//
// Ports
//   clk           system clock, rising edge
//   resetN        asynchronous active-low reset
//   win           single-cycle win request
//   lose          single-cycle lose request
//   clear         synchronous abort of queued and playing sounds
//   sound_freq    current note frequency in Hz (0 when silent)
//   enable_sound  tone generator enable
//   busy          FSM not idle or FIFO non-empty
//   overflow      sticky: a request was dropped because the FIFO was full
//   cur_event     sequence being played, 1 = win, 0 = lose
// ---------------------------------------------------------------------------
module sound_event_scheduler #(
    parameter int NOTE_TICKS = 5,
    parameter int GAP_TICKS  = 2
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       win,
    input  logic       lose,
    input  logic       clear,
    output logic [9:0] sound_freq,
    output logic       enable_sound,
    output logic       busy,
    output logic       overflow,
    output logic       cur_event
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_NOTE = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    localparam logic [25:0] NOTE_LOAD = 26'(NOTE_TICKS - 1);
    localparam logic [25:0] GAP_LOAD  = 26'(GAP_TICKS - 1);

    // Note table: event type (1 = win) and note index -> frequency in Hz.
    function automatic logic [9:0] note_freq(input logic ev, input logic [1:0] idx);
        logic [9:0] f;
        case ({ev, idx})
            3'b1_00: f = 10'd523;
            3'b1_01: f = 10'd659;
            3'b1_10: f = 10'd784;
            3'b0_00: f = 10'd392;
            3'b0_01: f = 10'd262;
            default: f = 10'd0;
        endcase
        return f;
    endfunction

    // True when idx is the final note of the sequence for this event type.
    function automatic logic is_last_note(input logic ev, input logic [1:0] idx);
        logic last;
        if (ev) begin
            last = (idx == 2'd2);
        end else begin
            last = (idx == 2'd1);
        end
        return last;
    endfunction

    state_t      state_q;
    logic [25:0] cnt_q;
    logic [1:0]  note_idx_q;
    logic [1:0]  fifo_q;      // slot 0 is the head
    logic [1:0]  count_q;     // occupancy 0..2
    logic [9:0]  sound_freq_q;
    logic        enable_q;
    logic        overflow_q;
    logic        cur_event_q;

    logic [1:0]  fifo_d;
    logic [1:0]  count_d;
    logic        pop_s;
    logic        ovf_set_s;

    // The GAP length is only consumed when the gap feature is built in.
    logic        unused_gap_s;
    assign unused_gap_s = ^GAP_LOAD;

    // The FSM pops only from IDLE, using the occupancy registered on the
    // previous edge, so a request written on edge N starts playing on N+1.
    assign pop_s = (state_q == ST_IDLE) && (count_q != 2'd0) && !clear;

    // FIFO next state: pop first (frees a slot), then push lose, then win.
    always_comb begin
        fifo_d    = fifo_q;
        count_d   = count_q;
        ovf_set_s = 1'b0;
        if (pop_s) begin
            fifo_d[0] = fifo_q[1];
            fifo_d[1] = 1'b0;
            count_d   = count_q - 2'd1;
        end else begin
            fifo_d    = fifo_q;
        end
        if (lose) begin
            if (count_d < 2'd2) begin
                fifo_d[count_d[0]] = 1'b0;
                count_d            = count_d + 2'd1;
            end else begin
                ovf_set_s = 1'b1;
            end
        end else begin
            ovf_set_s = ovf_set_s;
        end
        if (win) begin
            if (count_d < 2'd2) begin
                fifo_d[count_d[0]] = 1'b1;
                count_d            = count_d + 2'd1;
            end else begin
                ovf_set_s = 1'b1;
            end
        end else begin
            ovf_set_s = ovf_set_s;
        end
    end

    // Sequencer FSM, FIFO storage and registered outputs.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 26'd0;
            note_idx_q   <= 2'd0;
            fifo_q       <= 2'b00;
            count_q      <= 2'd0;
            sound_freq_q <= 10'd0;
            enable_q     <= 1'b0;
            overflow_q   <= 1'b0;
            cur_event_q  <= 1'b0;
        end else if (clear) begin
            // Abort: requests sampled in this cycle are discarded and do
            // not count as overflow.
            state_q      <= ST_IDLE;
            cnt_q        <= 26'd0;
            note_idx_q   <= 2'd0;
            fifo_q       <= 2'b00;
            count_q      <= 2'd0;
            sound_freq_q <= 10'd0;
            enable_q     <= 1'b0;
            cur_event_q  <= 1'b0;
        end else begin
            fifo_q     <= fifo_d;
            count_q    <= count_d;
            overflow_q <= overflow_q | ovf_set_s;
            case (state_q)
                ST_IDLE: begin
                    if (pop_s) begin
                        state_q      <= ST_NOTE;
                        cur_event_q  <= fifo_q[0];
                        note_idx_q   <= 2'd0;
                        cnt_q        <= NOTE_LOAD;
                        sound_freq_q <= note_freq(fifo_q[0], 2'd0);
                        enable_q     <= 1'b1;
                    end else begin
                        sound_freq_q <= 10'd0;
                        enable_q     <= 1'b0;
                    end
                end
                ST_NOTE: begin
                    if (cnt_q != 26'd0) begin
                        cnt_q <= cnt_q - 26'd1;
                    end else if (is_last_note(cur_event_q, note_idx_q)) begin
                        state_q      <= ST_IDLE;
                        note_idx_q   <= 2'd0;
                        sound_freq_q <= 10'd0;
                        enable_q     <= 1'b0;
                    end else begin
`ifdef SOUND_GAP_EN
                        state_q      <= ST_GAP;
                        note_idx_q   <= note_idx_q + 2'd1;
                        cnt_q        <= GAP_LOAD;
                        sound_freq_q <= 10'd0;
                        enable_q     <= 1'b0;
`else
                        state_q      <= ST_NOTE;
                        note_idx_q   <= note_idx_q + 2'd1;
                        cnt_q        <= NOTE_LOAD;
                        sound_freq_q <= note_freq(cur_event_q, note_idx_q + 2'd1);
                        enable_q     <= 1'b1;
`endif
                    end
                end
`ifdef SOUND_GAP_EN
                ST_GAP: begin
                    if (cnt_q != 26'd0) begin
                        cnt_q <= cnt_q - 26'd1;
                    end else begin
                        state_q      <= ST_NOTE;
                        cnt_q        <= NOTE_LOAD;
                        sound_freq_q <= note_freq(cur_event_q, note_idx_q);
                        enable_q     <= 1'b1;
                    end
                end
`endif
                default: begin
                    state_q      <= ST_IDLE;
                    cnt_q        <= 26'd0;
                    note_idx_q   <= 2'd0;
                    sound_freq_q <= 10'd0;
                    enable_q     <= 1'b0;
                end
            endcase
        end
    end

    assign sound_freq   = sound_freq_q;
    assign enable_sound = enable_q;
    assign overflow     = overflow_q;
    assign cur_event    = cur_event_q;
    assign busy         = (state_q != ST_IDLE) || (count_q != 2'd0);

endmodule

// File: tb/tb_sound_event_scheduler.sv
module tb_sound_event_scheduler;

    localparam int NT = 5;
    localparam int GT = 2;

    logic       clk;
    logic       resetN;
    logic       win;
    logic       lose;
    logic       clear;
    logic [9:0] sound_freq;
    logic       enable_sound;
    logic       busy;
    logic       overflow;
    logic       cur_event;

    int checks   = 0;
    int failures = 0;

    sound_event_scheduler #(.NOTE_TICKS(NT), .GAP_TICKS(GT)) dut (
        .clk          (clk),
        .resetN       (resetN),
        .win          (win),
        .lose         (lose),
        .clear        (clear),
        .sound_freq   (sound_freq),
        .enable_sound (enable_sound),
        .busy         (busy),
        .overflow     (overflow),
        .cur_event    (cur_event)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Each popped request is expanded into its full per-cycle output
    // schedule (notes, optional gaps, one trailing idle cycle).
    typedef struct packed {
        logic       act;
        logic       en;
        logic [9:0] f;
    } ent_t;

    ent_t       sched[$];
    bit         mq[$];
    logic       m_act, m_en, m_cur, m_ovf;
    logic [9:0] m_freq;

    function automatic logic [13:0] expv();
        return {m_en, m_freq, (m_act || mq.size() != 0), m_ovf, m_cur};
    endfunction

    function automatic logic [13:0] obsv();
        return {enable_sound, sound_freq, busy, overflow, cur_event};
    endfunction

    task automatic model_reset();
        sched.delete();
        mq.delete();
        m_act = 0; m_en = 0; m_cur = 0; m_ovf = 0; m_freq = 0;
    endtask

    task automatic build(input bit ev);
        int notes[$];
        if (ev) notes = '{523, 659, 784};
        else    notes = '{392, 262};
        for (int n = 0; n < notes.size(); n++) begin
            for (int t = 0; t < NT; t++) sched.push_back('{1'b1, 1'b1, 10'(notes[n])});
`ifdef SOUND_GAP_EN
            if (n != notes.size() - 1)
                for (int t = 0; t < GT; t++) sched.push_back('{1'b1, 1'b0, 10'd0});
`endif
        end
        sched.push_back('{1'b0, 1'b0, 10'd0});
    endtask

    task automatic model_step(input bit w, input bit l, input bit c);
        ent_t e;
        bit   ev;
        if (c) begin
            sched.delete(); mq.delete();
            m_act = 0; m_en = 0; m_freq = 0; m_cur = 0;
        end else begin
            if (!m_act && mq.size() > 0) begin
                ev = mq.pop_front();
                m_cur = ev;
                build(ev);
            end
            if (l) begin
                if (mq.size() < 2) mq.push_back(1'b0); else m_ovf = 1;
            end
            if (w) begin
                if (mq.size() < 2) mq.push_back(1'b1); else m_ovf = 1;
            end
            if (sched.size() > 0) begin
                e = sched.pop_front();
                m_act = e.act; m_en = e.en; m_freq = e.f;
            end else begin
                m_act = 0; m_en = 0; m_freq = 0;
            end
        end
    endtask

    // One clock: drive inputs at negedge, advance model at posedge,
    // return at the next negedge for sampling.
    task automatic tick(input bit w, input bit l, input bit c);
        win = w; lose = l; clear = c;
        @(posedge clk);
        model_step(w, l, c);
        @(negedge clk);
        win = 0; lose = 0; clear = 0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        resetN = 0; win = 0; lose = 0; clear = 0;
        model_reset();
        #3;
        checks++;
        if (obsv() !== 14'd0) begin
            failures++;
            $display("FAIL reset_state got=%h exp=%h", obsv(), 14'd0);
        end
        @(negedge clk);
        @(negedge clk);
        resetN = 1;
    endtask

    task automatic test_win_sequence();
        int en_cycles = 0;
        int exp_cycles;
        int seq_f[$];
        tick(1, 0, 0);
        for (int i = 0; i < 25; i++) begin
            if (i > 0) tick(0, 0, 0);
            checks++;
            if (obsv() !== expv()) begin
                failures++;
                $display("FAIL win_seq cyc=%0d got=%h exp=%h", i, obsv(), expv());
            end
            if (enable_sound === 1'b1) begin
                en_cycles++;
                seq_f.push_back(int'(sound_freq));
            end
        end
        exp_cycles = 3 * NT;
        checks++;
        if (en_cycles !== exp_cycles || seq_f.size() == 0 || seq_f[0] != 523
            || seq_f[seq_f.size()-1] != 784) begin
            failures++;
            $display("FAIL win_enable_cycles got=%0d exp=%0d", en_cycles, exp_cycles);
        end
        checks++;
        if (cur_event !== 1'b1 || enable_sound !== 1'b0 || sound_freq !== 10'd0) begin
            failures++;
            $display("FAIL win_end got cur=%b en=%b f=%0d exp cur=1 en=0 f=0",
                     cur_event, enable_sound, sound_freq);
        end
    endtask

    task automatic test_lose_sequence();
        tick(0, 1, 0);
        checks++;
        if (enable_sound !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL lose_latency got en=%b busy=%b exp en=0 busy=1", enable_sound, busy);
        end
        for (int i = 0; i < 20; i++) begin
            tick(0, 0, 0);
            checks++;
            if (obsv() !== expv()) begin
                failures++;
                $display("FAIL lose_seq cyc=%0d got=%h exp=%h", i, obsv(), expv());
            end
        end
    endtask

    task automatic test_simultaneous();
        tick(1, 1, 0);
        for (int i = 0; i < 40; i++) begin
            tick(0, 0, 0);
            checks++;
            if (obsv() !== expv()) begin
                failures++;
                $display("FAIL simul_seq cyc=%0d got=%h exp=%h", i, obsv(), expv());
            end
        end
        checks++;
        if (overflow !== 1'b0) begin
            failures++;
            $display("FAIL simul_overflow got=%b exp=0", overflow);
        end
    endtask

    task automatic test_overflow();
        tick(1, 0, 0);
        for (int i = 0; i < 70; i++) begin
            tick((i == 3 || i == 5 || i == 7), 0, 0);
            checks++;
            if (obsv() !== expv()) begin
                failures++;
                $display("FAIL ovf_seq cyc=%0d got=%h exp=%h", i, obsv(), expv());
            end
        end
        checks++;
        if (overflow !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL ovf_sticky got ovf=%b busy=%b exp ovf=1 busy=0", overflow, busy);
        end
    endtask

    task automatic test_clear();
        int n659 = 0;
        int budget = 0;
        tick(1, 0, 0);
        tick(0, 1, 0);
        while (n659 < 3 && budget < 40) begin
            tick(0, 0, 0);
            budget++;
            if (sound_freq === 10'd659) n659++;
        end
        checks++;
        if (n659 != 3) begin
            failures++;
            $display("FAIL clear_wait got=%0d exp=3 (timeout)", n659);
        end
        tick(0, 0, 1);
        checks++;
        if (obsv() !== expv() || enable_sound !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL clear_abort got=%h exp=%h", obsv(), expv());
        end
        for (int i = 0; i < 6; i++) begin
            tick(0, 0, 0);
            checks++;
            if (obsv() !== expv()) begin
                failures++;
                $display("FAIL clear_after cyc=%0d got=%h exp=%h", i, obsv(), expv());
            end
        end
    endtask

    task automatic test_reset_mid_note();
        tick(1, 0, 0);
        for (int i = 0; i < 4; i++) tick(0, 0, 0);
        resetN = 0;
        model_reset();
        #1;
        checks++;
        if (obsv() !== 14'd0) begin
            failures++;
            $display("FAIL reset_mid_note got=%h exp=%h", obsv(), 14'd0);
        end
        @(negedge clk);
        resetN = 1;
        tick(1, 0, 0);
        for (int i = 0; i < 20; i++) begin
            tick(0, 0, 0);
            checks++;
            if (obsv() !== expv()) begin
                failures++;
                $display("FAIL post_reset_seq cyc=%0d got=%h exp=%h", i, obsv(), expv());
            end
        end
    endtask

    task automatic test_random();
        bit w, l, c;
        for (int i = 0; i < 800; i++) begin
            w = ($urandom_range(99) < 8);
            l = ($urandom_range(99) < 8);
            c = ($urandom_range(199) < 3);
            tick(w, l, c);
            checks++;
            if (obsv() !== expv()) begin
                failures++;
                $display("FAIL random cyc=%0d w=%b l=%b c=%b got=%h exp=%h",
                         i, w, l, c, obsv(), expv());
            end
        end
    endtask

    initial begin
        test_reset();
        test_win_sequence();
        test_lose_sequence();
        test_simultaneous();
        test_overflow();
        test_clear();
        test_reset_mid_note();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sound_event_scheduler.md
SOUND_EVENT_SCHEDULER -- requirements
Module: sound_event_scheduler

Interface
REQ-001 Parameter NOTE_TICKS, default 5, clock cycles per note (50000000 on hardware); legal range 1..2^26-1.
REQ-002 Parameter GAP_TICKS, default 2, silent cycles between notes; legal range 1..255; used only when SOUND_GAP_EN is defined.
REQ-003 Port clk, input, 1 bit: single system clock; all state is updated on its rising edge.
REQ-004 Port resetN, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port win, input, 1 bit: single-cycle win event request.
REQ-006 Port lose, input, 1 bit: single-cycle lose event request.
REQ-007 Port clear, input, 1 bit: synchronous abort of all queued and playing sounds.
REQ-008 Port sound_freq, output, 10 bits: current note frequency in Hz.
REQ-009 Port enable_sound, output, 1 bit: tone generator enable.
REQ-010 Port busy, output, 1 bit: high when the state is not IDLE or the queue is non-empty.
REQ-011 Port overflow, output, 1 bit: sticky flag, set when a request is dropped.
REQ-012 Port cur_event, output, 1 bit: type of the sequence being played; 1 = win, 0 = lose.

Function
REQ-013 Requests SHALL be captured into a 2-entry FIFO of event types on the same edge on which they are sampled high.
REQ-014 When win and lose are high in the same cycle, lose SHALL be written first, then win.
REQ-015 A request arriving when the FIFO has no free slot SHALL be dropped and SHALL set overflow.
  - If only one slot is free on a simultaneous win+lose, lose is kept, win is dropped, and overflow is set.
REQ-016 A pop and a push in the same cycle SHALL be permitted; the slot freed by the pop is available to that push.
REQ-017 Note tables (sound_freq values):
  - Win: 523, 659, 784.
  - Lose: 392, 262.
REQ-018 The FSM SHALL have the states IDLE, NOTE and GAP.
REQ-019 IDLE with FIFO non-empty: on the next edge, pop the head entry, load cur_event, set note index 0, go to NOTE, and set enable_sound=1 with sound_freq equal to the table entry.
REQ-020 enable_sound SHALL therefore first be high on the cycle after the cycle in which the request was written (2 edges after request assertion).
REQ-021 NOTE SHALL last exactly NOTE_TICKS cycles, with sound_freq constant throughout.
REQ-022 At the end of a NOTE that is not the last note: go to GAP if SOUND_GAP_EN is defined, else go directly to the next NOTE.
REQ-023 GAP SHALL last exactly GAP_TICKS cycles with enable_sound=0 and sound_freq=0, then go to the next NOTE.
REQ-024 At the end of the last note, the FSM SHALL return to IDLE for at least one cycle, with enable_sound=0 and sound_freq=0, before popping the next entry.
REQ-025 clear SHALL take priority over all other inputs. On the next edge it empties the FIFO, drops win/lose sampled in the same cycle, goes to IDLE, and zeroes sound_freq, enable_sound and cur_event; overflow is unaffected.
REQ-026 The duration counter SHALL be 26 bits wide, load NOTE_TICKS-1 or GAP_TICKS-1, and count down to 0; it never wraps.
REQ-027 sound_freq, enable_sound and cur_event SHALL be registered outputs; busy SHALL be a combinational decode of registered state.

Reset
REQ-028 resetN low SHALL immediately force state IDLE, FIFO empty, counter 0, and sound_freq=0, enable_sound=0, busy=0, overflow=0, cur_event=0, including when asserted mid-note.
REQ-029 After resetN deasserts, the first request SHALL be accepted on the first rising edge.

Configuration
REQ-030 Macro SOUND_GAP_EN:
  - When defined, the GAP state is compiled in and GAP_TICKS silent cycles separate consecutive notes of a sequence.
  - When undefined, GAP logic is absent and notes play back-to-back with no idle cycle between them.

Verification
REQ-031 No gap, NOTE_TICKS=5, win pulse -> enable_sound high for 15 cycles: 523 x5, 659 x5, 784 x5; then 0; cur_event=1.
REQ-032 SOUND_GAP_EN, GAP_TICKS=2, lose pulse -> 392 x5, 0 x2, 262 x5; total 12 cycles; busy falls after the IDLE return.
REQ-033 Simultaneous win+lose on an empty queue -> lose sequence, 1 idle cycle, win sequence; overflow stays 0.
REQ-034 While playing, three further win pulses -> two queued, the third dropped, overflow=1 until reset.
REQ-035 clear on the 3rd cycle of note 659 -> enable_sound=0 and sound_freq=0 on the next cycle; busy=0; queued entries discarded.
REQ-036 resetN asserted mid-note -> all outputs 0 immediately, without waiting for a clock edge; a win pulse after release plays normally.
